matrix_loader: RTL and testbench

- Host-side writer that fills the A and B global buffers the tpu core reads, then launches the tpu and waits for it to finish.
- Accepts an 8-bit element stream with a valid/ready handshake. A arrives row-major. B arrives transposed (B^T row-major, i.e. one B column at a time).
- Packs 4-row strips into 32-bit column words, writes them with wr_en/index/data, pulses tpu_start, and waits for tpu_done.

---
 rtl/matrix_loader.sv | 194 +++++++++++++++++++
 tb/tb_matrix_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Host-side loader: packs A / B^T element streams into 4-row column words, then launches the tpu.
// Optional: define MATRIX_LOADER_PERF_EN to add the perf_cycles / perf_stall counters.
module matrix_loader #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 8,
   parameter int MAX_K  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [3:0]        m,
   input  logic [3:0]        k,
   input  logic [3:0]        n,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              wr_en_a,
   output logic [IDX_W-1:0]  index_a,
   output logic [WORD_W-1:0] datain_a,
   output logic              wr_en_b,
   output logic [IDX_W-1:0]  index_b,
   output logic [WORD_W-1:0] datain_b,
   output logic              tpu_start,
   input  logic              tpu_done,
   output logic              busy,
   output logic              err
`ifdef MATRIX_LOADER_PERF_EN
   ,
   output logic [15:0]       perf_cycles,
   output logic [15:0]       perf_stall
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_FLUSH_A, S_LOAD_B, S_FLUSH_B, S_START, S_WAIT
   } state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_m, r_k, r_n, r_col, r_fc;
   logic [1:0]  r_row, r_strip;
   logic [7:0]  r_stage [4][MAX_K];
   logic        r_err;

   logic        w_load, w_flush, w_is_b, w_xfer, w_cfg_ok;
   logic        w_strip_done, w_flush_last, w_more;
   logic [3:0]  w_total;
   logic [4:0]  w_rows_left;
   logic [2:0]  w_strip_rows;
   logic [5:0]  w_idx;
   logic [WORD_W-1:0] w_word;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign w_load       = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign w_flush      = (r_state == S_FLUSH_A) || (r_state == S_FLUSH_B);
   assign w_is_b       = (r_state == S_LOAD_B) || (r_state == S_FLUSH_B);
   assign w_xfer       = w_load && s_valid;
   assign w_cfg_ok     = (m != 4'd0) && (k != 4'd0) && (n != 4'd0) && (int'(k) <= MAX_K);
   assign w_total      = w_is_b ? r_n : r_m;
   assign w_rows_left  = {1'b0, w_total} - {1'b0, r_strip, 2'b00};
   assign w_strip_rows = (w_rows_left >= 5'd4) ? 3'd4 : w_rows_left[2:0];
   assign w_strip_done = w_xfer && (r_col == r_k - 4'd1) && ({1'b0, r_row} == w_strip_rows - 3'd1);
   assign w_flush_last = w_flush && (r_fc == r_k - 4'd1);
   assign w_more       = ({1'b0, r_strip, 2'b00} + 5'd4) < {1'b0, w_total};
   assign w_idx        = 6'(r_strip) * 6'(r_k) + 6'(r_fc);
   assign busy         = (r_state != S_IDLE);
   assign err          = r_err;

   // Lane 0 sits in the top byte; rows past the matrix edge stay zero.
   always_comb begin
      w_word = '0;
      for (int r = 0; r < 4; r++) begin
         if (3'(r) < w_strip_rows) w_word[WORD_W-1-8*r -: 8] = r_stage[r][r_fc];
      end
   end

   always_comb begin
      w_next    = r_state;
      s_ready   = 1'b0;
      wr_en_a   = 1'b0;
      index_a   = '0;
      datain_a  = '0;
      wr_en_b   = 1'b0;
      index_b   = '0;
      datain_b  = '0;
      tpu_start = 1'b0;
      case (r_state)
         S_IDLE: if (cfg_valid && w_cfg_ok) w_next = S_LOAD_A;
         S_LOAD_A: begin
            s_ready = 1'b1;
            if (w_strip_done) w_next = S_FLUSH_A;
         end
         S_FLUSH_A: begin
            wr_en_a  = 1'b1;
            index_a  = IDX_W'(w_idx);
            datain_a = w_word;
            if (w_flush_last) w_next = w_more ? S_LOAD_A : S_LOAD_B;
         end
         S_LOAD_B: begin
            s_ready = 1'b1;
            if (w_strip_done) w_next = S_FLUSH_B;
         end
         S_FLUSH_B: begin
            wr_en_b  = 1'b1;
            index_b  = IDX_W'(w_idx);
            datain_b = w_word;
            if (w_flush_last) w_next = w_more ? S_LOAD_B : S_START;
         end
         S_START: begin
            tpu_start = 1'b1;
            w_next    = S_WAIT;
         end
         S_WAIT: if (tpu_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_k     <= '0;
         r_n     <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_fc    <= '0;
         r_strip <= '0;
         r_err   <= 1'b0;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < MAX_K; c++) r_stage[r][c] <= '0;
      end else begin
         r_state <= w_next;
         r_err   <= 1'b0;
         if (r_state == S_IDLE && cfg_valid) begin
            if (w_cfg_ok) begin
               r_m     <= m;
               r_k     <= k;
               r_n     <= n;
               r_col   <= '0;
               r_row   <= '0;
               r_fc    <= '0;
               r_strip <= '0;
            end else begin
               r_err <= 1'b1;
            end
         end
         if (w_xfer) begin
            r_stage[r_row][r_col] <= s_data;
            if (w_strip_done) begin
               r_col <= '0;
               r_row <= '0;
               r_fc  <= '0;
            end else if (r_col == r_k - 4'd1) begin
               r_col <= '0;
               r_row <= r_row + 2'd1;
            end else begin
               r_col <= r_col + 4'd1;
            end
         end
         if (w_flush) begin
            r_fc <= r_fc + 4'd1;
            if (w_flush_last) begin
               r_fc    <= '0;
               r_strip <= w_more ? r_strip + 2'd1 : 2'd0;
               for (int r = 0; r < 4; r++)
                  for (int c = 0; c < MAX_K; c++) r_stage[r][c] <= '0;
            end
         end
      end
   end

`ifdef MATRIX_LOADER_PERF_EN
   logic [15:0] r_perf_cycles, r_perf_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_cycles <= '0;
         r_perf_stall  <= '0;
      end else if (r_state == S_IDLE && cfg_valid && w_cfg_ok) begin
         r_perf_cycles <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (busy) r_perf_cycles <= sat_inc(r_perf_cycles);
         if (w_load && !s_valid) r_perf_stall <= sat_inc(r_perf_stall);
      end
   end

   assign perf_cycles = r_perf_cycles;
   assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: queue-based write model plus per-cycle output monitor.
module tb_matrix_loader;
   localparam int IDX_W = 8;

   logic             clk = 1'b0;
   logic             rst, cfg_valid, s_valid, tpu_done;
   logic [3:0]       m_in, k_in, n_in;
   logic [7:0]       s_data;
   logic             s_ready, wr_en_a, wr_en_b, tpu_start, busy, err;
   logic [IDX_W-1:0] index_a, index_b;
   logic [31:0]      datain_a, datain_b;
`ifdef MATRIX_LOADER_PERF_EN
   logic [15:0]      perf_cycles, perf_stall;
`endif

   matrix_loader #(.WORD_W(32), .IDX_W(IDX_W), .MAX_K(15)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .m(m_in), .k(k_in), .n(n_in),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .wr_en_a(wr_en_a), .index_a(index_a), .datain_a(datain_a),
      .wr_en_b(wr_en_b), .index_b(index_b), .datain_b(datain_b),
      .tpu_start(tpu_start), .tpu_done(tpu_done), .busy(busy), .err(err)
`ifdef MATRIX_LOADER_PERF_EN
      , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } wr_t;

   wr_t exp_a[$];
   wr_t exp_b[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  start_cnt = 0;
   int  busy_cycles = 0;
   bit  prev_wr_a = 0, prev_wr_b = 0, prev_start = 0, prev_xfer = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected writes for one matrix given as rows of length k (A, or B^T).
   task automatic model(input int rows, input int k, input int base, input bit is_b);
      wr_t w;
      for (int s = 0; s * 4 < rows; s++) begin
         for (int c = 0; c < k; c++) begin
            w.idx  = s * k + c;
            w.data = 32'h0;
            for (int r = 0; r < 4; r++) begin
               if (4 * s + r < rows)
                  w.data = w.data | (32'((base + (4 * s + r) * k + c) & 8'hFF) << (24 - 8 * r));
            end
            if (is_b) exp_b.push_back(w);
            else exp_a.push_back(w);
         end
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (wr_en_a) begin
         if (exp_a.size() == 0) chk("a_unexpected_write", 32'd1, 32'd0);
         else begin
            e = exp_a.pop_front();
            chk("a_index", 32'(index_a), 32'(e.idx));
            chk("a_data", datain_a, e.data);
         end
         chk("a_ready_in_flush", 32'(s_ready), 32'd0);
         if (!prev_wr_a) chk("a_flush_latency", 32'(prev_xfer), 32'd1);
      end
      if (wr_en_b) begin
         if (exp_b.size() == 0) chk("b_unexpected_write", 32'd1, 32'd0);
         else begin
            e = exp_b.pop_front();
            chk("b_index", 32'(index_b), 32'(e.idx));
            chk("b_data", datain_b, e.data);
         end
         chk("b_ready_in_flush", 32'(s_ready), 32'd0);
         if (!prev_wr_b) chk("b_flush_latency", 32'(prev_xfer), 32'd1);
      end
      if (tpu_start) begin
         chk("start_after_last_b", 32'(prev_wr_b && exp_b.size() == 0), 32'd1);
         chk("start_one_cycle", 32'(prev_start), 32'd0);
         start_cnt++;
      end
      if (busy) busy_cycles++;
      prev_wr_a  = wr_en_a;
      prev_wr_b  = wr_en_b;
      prev_start = tpu_start;
      prev_xfer  = s_valid && s_ready;
   end

   task automatic cfg(input int m, input int k, input int n);
      m_in = 4'(m);
      k_in = 4'(k);
      n_in = 4'(n);
      cfg_valid = 1'b1;
      @(posedge clk) #1;
      cfg_valid = 1'b0;
   endtask

   task automatic push(input int d, input bit gaps);
      int i;
      if (gaps && $urandom_range(0, 1) == 1) begin
         s_valid = 1'b0;
         @(posedge clk) #1;
      end
      s_valid = 1'b1;
      s_data  = 8'(d);
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_ready) break;
      end
      if (i == 100) chk("push_timeout", 32'd0, 32'd1);
      @(posedge clk) #1;
   endtask

   task automatic run(input int m, input int k, input int n, input int abase, input int bbase,
                      input bit gaps, input int wait_cyc, input bit cfg_in_wait);
      int  i;
      bit  busy_ok;
      start_cnt   = 0;
      busy_cycles = 0;
      cfg(m, k, n);
      chk("busy_after_cfg", 32'(busy), 32'd1);
      for (int j = 0; j < m * k; j++) push(abase + j, gaps);
      for (int j = 0; j < n * k; j++) push(bbase + j, 1'b0);
      s_valid = 1'b0;
      for (i = 0; i < 300; i++) begin
         if (tpu_start) break;
         @(negedge clk);
      end
      if (i == 300) chk("start_timeout", 32'd0, 32'd1);
      @(posedge clk) #1;
      busy_ok = 1'b1;
      for (int j = 0; j < wait_cyc; j++) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (cfg_in_wait && j == 5) begin
            m_in = 4'd2; k_in = 4'd2; n_in = 4'd2;
            cfg_valid = 1'b1;
         end
         @(posedge clk) #1;
         cfg_valid = 1'b0;
      end
      chk("busy_in_wait", 32'(busy_ok), 32'd1);
      tpu_done = 1'b1;
      @(posedge clk) #1;
      tpu_done = 1'b0;
      chk("busy_drop_after_done", 32'(busy), 32'd0);
      chk("start_count", 32'(start_cnt), 32'd1);
      chk("a_all_written", 32'(exp_a.size()), 32'd0);
      chk("b_all_written", 32'(exp_b.size()), 32'd0);
`ifdef MATRIX_LOADER_PERF_EN
      chk("perf_cycles", 32'(perf_cycles), 32'(busy_cycles));
`endif
      repeat (2) @(posedge clk) #1;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; s_valid = 1'b0; s_data = 8'h0; tpu_done = 1'b0;
      m_in = 4'd0; k_in = 4'd0; n_in = 4'd0;
      repeat (2) @(posedge clk) #1;
      chk("reset_outputs", 32'(|{wr_en_a, wr_en_b, tpu_start, busy, err, s_ready,
                               index_a, index_b, datain_a, datain_b}), 32'd0);
      rst = 1'b0;
      @(posedge clk) #1;

      // Scenario 1: 4x2x4, A = 1..8, B^T = 9..16
      model(4, 2, 1, 1'b0);
      model(4, 2, 9, 1'b1);
      chk("pin_a0", exp_a[0].data, 32'h01030507);
      chk("pin_a1", exp_a[1].data, 32'h02040608);
      chk("pin_b0", exp_b[0].data, 32'h090B0D0F);
      chk("pin_b1", exp_b[1].data, 32'h0A0C0E10);
      run(4, 2, 4, 1, 9, 1'b0, 3, 1'b0);

      // Scenario 2: 5x3x1, partial strips
      model(5, 3, 1, 1'b0);
      model(1, 3, 8'h21, 1'b1);
      chk("pin_a3", exp_a[3].data, 32'h0D000000);
      chk("pin_b0_edge", exp_b[0].data, 32'h21000000);
      run(5, 3, 1, 1, 8'h21, 1'b0, 2, 1'b0);

      // Scenario 3: scenario 1 with gaps on the A stream
      model(4, 2, 1, 1'b0);
      model(4, 2, 9, 1'b1);
      run(4, 2, 4, 1, 9, 1'b1, 2, 1'b0);

      // Illegal config k=0, then a legal one
      start_cnt = 0;
      cfg(3, 0, 3);
      @(negedge clk);
      chk("err_pulse", 32'(err), 32'd1);
      @(negedge clk);
      chk("err_one_cycle", 32'(err), 32'd0);
      repeat (3) @(posedge clk) #1;
      chk("err_no_start", 32'(start_cnt), 32'd0);
      model(4, 2, 1, 1'b0);
      model(4, 2, 9, 1'b1);
      run(4, 2, 4, 1, 9, 1'b0, 2, 1'b0);

      // Reset during FLUSH_A
      model(4, 2, 1, 1'b0);
      model(4, 2, 9, 1'b1);
      cfg(4, 2, 4);
      for (int j = 0; j < 8; j++) push(1 + j, 1'b0);
      s_valid = 1'b0;
      chk("in_flush_before_rst", 32'(wr_en_a), 32'd1);
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      exp_a.delete();
      exp_b.delete();
      chk("rst_mid_outputs", 32'(|{wr_en_a, wr_en_b, tpu_start, busy, err, s_ready,
                                 index_a, index_b, datain_a, datain_b}), 32'd0);
      repeat (4) @(posedge clk) #1;
      model(4, 2, 1, 1'b0);
      model(4, 2, 9, 1'b1);
      run(4, 2, 4, 1, 9, 1'b0, 2, 1'b0);

      // Long WAIT with an ignored cfg_valid
      model(4, 2, 1, 1'b0);
      model(4, 2, 9, 1'b1);
      run(4, 2, 4, 1, 9, 1'b0, 50, 1'b1);
      chk("idle_after_wait_cfg", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
